// File: rtl/axi4lite_copy_ctrl_if.sv
// AXI4-Lite bus bundle for the block-copy master; master modport drives the
// request side, slave modport the response side.
interface axi4lite_copy_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4lite_copy_ctrl.sv
// AXI4-Lite master copying len consecutive words from src_base to dst_base, one
// read then one write per word. Define COPY_CTRL_ABORT_ON_ERR_EN to stop on the first error.
module axi4lite_copy_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [LEN_WIDTH-1:0]  o_err_cnt,
  output logic [LEN_WIDTH-1:0]  o_words_done,
  axi4lite_copy_ctrl_if.master  m_axi
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_zero_hold;
  logic                  r_err;
  logic [LEN_WIDTH-1:0]  r_err_cnt;
  logic [LEN_WIDTH-1:0]  r_words_done;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [LEN_WIDTH-1:0]  w_idx_inc;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_rd_err, w_b_err, w_err_evt;

  assign w_offset  = ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(BYTES);
  assign w_idx_inc = r_idx + 1'b1;
  assign w_ar_hs   = (r_state == S_RD_ADDR) && m_axi.arready;
  assign w_r_hs    = (r_state == S_RD_DATA) && m_axi.rvalid;
  assign w_aw_hs   = (r_state == S_WR) && !r_aw_done && m_axi.awready;
  assign w_w_hs    = (r_state == S_WR) && !r_w_done && m_axi.wready;
  assign w_b_hs    = (r_state == S_WR_RESP) && m_axi.bvalid;
  assign w_rd_err  = (m_axi.rresp != 2'b00);
  assign w_b_err   = (m_axi.bresp != 2'b00);
  assign w_err_evt = (w_r_hs && w_rd_err) || (w_b_hs && w_b_err);

  // Addresses derive from latched bases, so they cannot move while a valid is up.
  assign m_axi.araddr = r_src + w_offset;
  assign m_axi.awaddr = r_dst + w_offset;
  assign m_axi.wdata  = r_wdata;
  assign m_axi.wstrb  = '1;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

  assign o_err        = r_err;
  assign o_err_cnt    = r_err_cnt;
  assign o_words_done = r_words_done;

  always_comb begin
    w_state_next  = r_state;
    o_busy        = (r_state != S_IDLE);
    o_done        = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = (i_len == '0) ? S_DONE : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        m_axi.arvalid = 1'b1;
        if (w_ar_hs) w_state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi.rready = 1'b1;
        if (w_r_hs) begin
          w_state_next = S_WR;
`ifdef COPY_CTRL_ABORT_ON_ERR_EN
          if (w_rd_err) w_state_next = S_DONE;
`endif
        end
      end
      S_WR: begin
        m_axi.awvalid = !r_aw_done;
        m_axi.wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_axi.bready = 1'b1;
        if (w_b_hs) begin
          w_state_next = (w_idx_inc < r_len) ? S_RD_ADDR : S_DONE;
`ifdef COPY_CTRL_ABORT_ON_ERR_EN
          if (w_b_err) w_state_next = S_DONE;
`endif
        end
      end
      S_DONE: begin
        // A zero-length run spends one silent cycle here so busy spans two cycles.
        o_done = !r_zero_hold;
        if (!r_zero_hold) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_zero_hold  <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
      r_words_done <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src        <= i_src_base;
            r_dst        <= i_dst_base;
            r_len        <= i_len;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_words_done <= '0;
            r_zero_hold  <= (i_len == '0);
          end
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_wdata   <= m_axi.rdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) r_w_done <= 1'b1;
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_words_done <= r_words_done + 1'b1;
            r_idx        <= w_idx_inc;
          end
        end
        S_DONE: r_zero_hold <= 1'b0;
        default: ;
      endcase
      if (w_err_evt) begin
        r_err <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_copy_ctrl.sv
// Directed bench for axi4lite_copy_ctrl with a small AXI4-Lite slave model
// returning 0xA0 + word index and optional read-error / AW-delay injection.
module tb_axi4lite_copy_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_src_base = '0;
  logic [31:0] i_dst_base = '0;
  logic [15:0] i_len = '0;
  logic        o_busy, o_done, o_err;
  logic [15:0] o_err_cnt, o_words_done;

  axi4lite_copy_ctrl_if bus ();

  axi4lite_copy_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_src_base   (i_src_base),
    .i_dst_base   (i_dst_base),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_err_cnt    (o_err_cnt),
    .o_words_done (o_words_done),
    .m_axi        (bus.master)
  );

  always #5 clk = ~clk;

  // Slave model state
  logic        log_clr = 1'b0;
  logic [31:0] tb_src = '0;
  int          aw_delay = 0;
  int          rerr_idx = -1;
  int          ar_n, b_n, valid_cnt;
  int          aw_hold_cnt, w_hold_cnt, aw_hold_max, w_hold_max;
  logic        aw_got, w_got, aw_unstable;
  logic [31:0] aw_prev;
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];

  assign bus.arready = 1'b1;
  assign bus.wready  = 1'b1;
  assign bus.bresp   = 2'b00;
  assign bus.awready = (aw_hold_cnt >= aw_delay);

  always @(posedge clk) begin
    if (rst || log_clr) begin
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= 2'b00;
      bus.bvalid  <= 1'b0;
      ar_n <= 0; b_n <= 0; valid_cnt <= 0;
      aw_hold_cnt <= 0; w_hold_cnt <= 0; aw_hold_max <= 0; w_hold_max <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_unstable <= 1'b0; aw_prev <= '0;
      ar_q.delete(); aw_q.delete(); wd_q.delete();
    end else begin
      if (bus.arvalid || bus.awvalid || bus.wvalid) valid_cnt <= valid_cnt + 1;
      if (bus.arvalid && bus.arready) begin
        ar_q.push_back(bus.araddr);
        bus.rvalid <= 1'b1;
        bus.rdata  <= 32'hA0 + ((bus.araddr - tb_src) >> 2);
        bus.rresp  <= (ar_n == rerr_idx) ? 2'b10 : 2'b00;
        ar_n <= ar_n + 1;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      if (bus.awvalid) begin
        if (aw_hold_cnt != 0 && bus.awaddr != aw_prev) aw_unstable <= 1'b1;
        aw_prev <= bus.awaddr;
        if (bus.awready) begin
          aw_q.push_back(bus.awaddr);
          if (aw_hold_cnt + 1 > aw_hold_max) aw_hold_max <= aw_hold_cnt + 1;
          aw_hold_cnt <= 0;
        end else begin
          aw_hold_cnt <= aw_hold_cnt + 1;
        end
      end
      if (bus.wvalid) begin
        if (bus.wready) begin
          wd_q.push_back(bus.wdata);
          if (w_hold_cnt + 1 > w_hold_max) w_hold_max <= w_hold_cnt + 1;
          w_hold_cnt <= 0;
        end else begin
          w_hold_cnt <= w_hold_cnt + 1;
        end
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        b_n <= b_n + 1;
      end else if ((aw_got || (bus.awvalid && bus.awready)) &&
                   (w_got || (bus.wvalid && bus.wready))) begin
        bus.bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (bus.awvalid && bus.awready) aw_got <= 1'b1;
        if (bus.wvalid && bus.wready) w_got <= 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start and waits (bounded) for done; edges counts from the start-sample edge.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                          input bit restart, output int edges, output int busy_cyc, output logic ar_first);
    tb_src = src;
    @(negedge clk);
    i_src_base = src; i_dst_base = dst; i_len = len;
    i_start = 1'b1; log_clr = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0; log_clr = 1'b0;
    edges = 0; busy_cyc = 0;
    @(negedge clk);
    ar_first = bus.arvalid;
    forever begin
      if (o_busy) busy_cyc++;
      if (o_done || edges >= 400) break;
      if (restart && edges == 3) begin
        i_start = 1'b1; i_src_base = 32'h5000; i_len = 16'd9;
      end
      @(posedge clk);
      edges++;
      #1 i_start = 1'b0;
      @(negedge clk);
    end
    $display("run src=0x%08h dst=0x%08h len=%0d edges=%0d words_done=%0d err_cnt=%0d",
             src, dst, len, edges, o_words_done, o_err_cnt);
  endtask

  int   edges, busy_cyc, wait_cyc;
  logic ar_first;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_err", o_err, 0);
    check_val("rst_err_cnt", o_err_cnt, 0);
    check_val("rst_words_done", o_words_done, 0);
    check_val("rst_handshake", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
    check_val("rst_addr", {bus.araddr, bus.awaddr}, 0);
    check_val("rst_wdata", bus.wdata, 0);
    rst = 1'b0;

    // Basic 4-word copy
    run_copy(32'h1000, 32'h2000, 16'd4, 1'b0, edges, busy_cyc, ar_first);
    check_val("cp_ar_first", ar_first, 1);
    check_val("cp_edges", edges, 16);
    check_val("cp_busy_cyc", busy_cyc, 17);
    check_val("cp_ar_cnt", ar_q.size(), 4);
    check_val("cp_aw_cnt", aw_q.size(), 4);
    for (int i = 0; i < 4 && i < aw_q.size() && i < ar_q.size() && i < wd_q.size(); i++) begin
      check_val($sformatf("cp_araddr%0d", i), ar_q[i], 32'h1000 + 32'(i) * 4);
      check_val($sformatf("cp_awaddr%0d", i), aw_q[i], 32'h2000 + 32'(i) * 4);
      check_val($sformatf("cp_wdata%0d", i), wd_q[i], 32'hA0 + 32'(i));
    end
    check_val("cp_words_done", o_words_done, 4);
    check_val("cp_err", o_err, 0);
    @(negedge clk);
    check_val("cp_busy_after", o_busy, 0);
    check_val("cp_done_after", o_done, 0);

    // Zero-length run
    run_copy(32'h1000, 32'h2000, 16'd0, 1'b0, edges, busy_cyc, ar_first);
    check_val("z_edges", edges, 1);
    check_val("z_busy_cyc", busy_cyc, 2);
    check_val("z_ar_first", ar_first, 0);
    check_val("z_valid_cnt", valid_cnt, 0);
    @(negedge clk);
    check_val("z_busy_after", o_busy, 0);

    // AW backpressure of 3 cycles
    aw_delay = 3;
    run_copy(32'h3000, 32'h4000, 16'd2, 1'b0, edges, busy_cyc, ar_first);
    check_val("bp_edges", edges, 14);
    check_val("bp_aw_hold", aw_hold_max, 4);
    check_val("bp_w_hold", w_hold_max, 1);
    check_val("bp_aw_stable", aw_unstable, 0);
    check_val("bp_b_cnt", b_n, 2);
    check_val("bp_awaddr1", (aw_q.size() > 1) ? aw_q[1] : 32'hX, 32'h4004);
    check_val("bp_wdata1", (wd_q.size() > 1) ? wd_q[1] : 32'hX, 32'hA1);
    aw_delay = 0;

    // Read error on word 1 of 3
    rerr_idx = 1;
    run_copy(32'h1000, 32'h2000, 16'd3, 1'b0, edges, busy_cyc, ar_first);
    check_val("re_err", o_err, 1);
    check_val("re_err_cnt", o_err_cnt, 1);
`ifdef COPY_CTRL_ABORT_ON_ERR_EN
    check_val("re_words_done", o_words_done, 1);
    check_val("re_aw_cnt", aw_q.size(), 1);
    check_val("re_edges", edges, 6);
`else
    check_val("re_words_done", o_words_done, 3);
    check_val("re_aw_cnt", aw_q.size(), 3);
    check_val("re_edges", edges, 12);
    check_val("re_wdata1", (wd_q.size() > 1) ? wd_q[1] : 32'hX, 32'hA1);
`endif
    rerr_idx = -1;

    // Address wrap plus an ignored mid-run start
    run_copy(32'hFFFF_FFFC, 32'h2000, 16'd2, 1'b1, edges, busy_cyc, ar_first);
    check_val("wr_araddr0", (ar_q.size() > 0) ? ar_q[0] : 32'hX, 32'hFFFF_FFFC);
    check_val("wr_araddr1", (ar_q.size() > 1) ? ar_q[1] : 32'hX, 32'h0000_0000);
    check_val("wr_edges", edges, 8);
    check_val("wr_ar_cnt", ar_q.size(), 2);
    check_val("wr_words_done", o_words_done, 2);
    check_val("wr_err", o_err, 0);
    @(negedge clk);
    check_val("wr_busy_after", o_busy, 0);

    // Reset while awvalid is high
    tb_src = 32'h1000;
    @(negedge clk);
    i_src_base = 32'h1000; i_dst_base = 32'h2000; i_len = 16'd3;
    i_start = 1'b1; log_clr = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0; log_clr = 1'b0;
    wait_cyc = 0;
    @(negedge clk);
    while (!bus.awvalid && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_val("rr_awvalid_seen", bus.awvalid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rr_status", {o_busy, o_done, o_err, o_err_cnt, o_words_done}, 0);
    check_val("rr_handshake", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
    check_val("rr_addr_data", {bus.araddr, bus.awaddr, bus.wdata}, 0);
    $display("reset applied mid-write after %0d wait cycles", wait_cyc);
    run_copy(32'h1000, 32'h2000, 16'd2, 1'b0, edges, busy_cyc, ar_first);
    check_val("rr_edges", edges, 8);
    check_val("rr_err_cnt", o_err_cnt, 0);
    check_val("rr_words_done", o_words_done, 2);
    check_val("rr_b_cnt", b_n, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4lite_copy_ctrl.md
# axi4lite_copy_ctrl

- AXI4-Lite master that copies a block of consecutive words from the source regbank to the target regbank through the smartconnect.
- Occupies the second master slot of the interconnect, alongside the CPU.
- Its configuration inputs (`start`, addresses, length) are driven from CSR `hwif_out` fields; its status outputs feed `hwif_in`.
- Transactions are strictly sequential: one read, then one write per word, with at most one outstanding transaction.

## Interface

Parameters
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width. Byte stride per word is `DATA_WIDTH/8`.
- `LEN_WIDTH`, 16: width of the word count and progress counters.

Ports
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Configuration and status:
  - `start`  in  1  one-cycle request; sampled only in IDLE.
  - `src_base`  in  `ADDR_WIDTH`  first source address, latched on start.
  - `dst_base`  in  `ADDR_WIDTH`  first destination address, latched on start.
  - `len`  in  `LEN_WIDTH`  number of words to copy, latched on start.
  - `busy`  out  1  high from the start-sample edge until DONE.
  - `done`  out  1  one-cycle pulse at completion.
  - `err`  out  1  sticky flag for any non-OKAY response; cleared on the next accepted start.
  - `err_cnt`  out  `LEN_WIDTH`  count of non-OKAY responses in the current run.
  - `words_done`  out  `LEN_WIDTH`  words whose write has completed with B accepted.
- AXI4-Lite master, `m_axi_*`: AW, W, B, AR and R channels.
  - `awaddr`/`araddr` are `ADDR_WIDTH`; `wdata`/`rdata` are `DATA_WIDTH`.
  - `wstrb` is all ones; `awprot`/`arprot` are `3'b000`.
  - `bresp`/`rresp` are 2 bits; all valid/ready signals are 1 bit.

## Operation

- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE, on start:
  - latch `src_base`, `dst_base` and `len`;
  - clear the word index, `err`, `err_cnt` and `words_done`;
  - go to DONE if `len==0`, else to RD_ADDR.
- RD_ADDR:
  - `arvalid=1`, `araddr = src_base + idx*DATA_WIDTH/8`, computed modulo 2^`ADDR_WIDTH` (wraps silently);
  - go to RD_DATA on `arvalid&arready`.
- RD_DATA:
  - `rready=1`;
  - on R handshake, register `rdata` into the write-data register, record `rresp`, go to WR.
- WR:
  - `awvalid` and `wvalid` rise together; `awaddr` uses the same formula with `dst_base`.
  - Each valid drops independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both have completed.
- WR_RESP:
  - `bready=1`;
  - on B handshake, increment `words_done`;
  - increment `idx`, then go to RD_ADDR if `idx<len`, else to DONE.
- DONE:
  - `done=1` for one cycle;
  - next state is IDLE, and `busy` drops on that edge.
- Errors: `rresp!=0` or `bresp!=0` sets `err` and increments `err_cnt`, saturating at all ones.
- `start` is ignored outside IDLE.
- Valid signals never drop before their handshake. Address and data stay stable while valid is high.

## Timing

- Reset values: all valid and ready outputs 0; `busy`, `done`, `err` 0; `err_cnt` and `words_done` 0; addresses and `wdata` 0; state IDLE.
- `rst` sampled high at any edge, including mid-transaction, returns everything to reset values at that edge. Abandoning an in-flight handshake is accepted; the interconnect is reset on the same `rst`.
- Latency, with the start-sample edge numbered 0:
  - `arvalid` is high in the cycle after edge 0.
  - With a slave that has ready always high and single-cycle responses, each word takes 4 edges (AR, R, AW+W, B).
  - `done` is high in the cycle after edge 4·`len`.
  - For `len==0`, `done` is high in the cycle after edge 1, with no bus traffic.
- `busy` and `done` overlap in the DONE cycle.

## Configuration

- `COPY_CTRL_ABORT_ON_ERR_EN` defined:
  - A non-OKAY `rresp` skips the write and goes to DONE.
  - A non-OKAY `bresp` goes to DONE after the B handshake, with `words_done` still incremented.
  - Remaining words are not copied.
- Not defined:
  - Errors are only counted.
  - On a read error, the returned `rdata` is still written.
  - The run always covers `len` words.

## Test plan

- Copy `len=4`, `src=0x1000`, `dst=0x2000`, source words `0xA0..0xA3`, slave always ready:
  - AR addresses `0x1000..0x100C`; AW addresses `0x2000..0x200C` carrying `0xA0..0xA3`.
  - `done` in the cycle after edge 16; `words_done=4`, `err=0`.
- `len=0`: no valid asserted; `done` pulses in the cycle after edge 1; `busy` high for exactly 2 cycles.
- Write-side backpressure, `awready` delayed 3 cycles and `wready` immediate:
  - `wvalid` drops after 1 cycle; `awvalid` is held 4 cycles with `awaddr` stable;
  - exactly one B is accepted per word.
- Read error on word 1 of 3 (`rresp=2'b10`):
  - With the macro: `err=1`, `err_cnt=1`, `words_done=1`, no second AW.
  - Without the macro: `err_cnt=1`, `words_done=3`.
- `src=0xFFFF_FFFC`, `len=2`: second `araddr` is `0x0000_0000`. A second `start` pulsed mid-run is ignored.
- `rst` pulsed while `awvalid=1`:
  - all outputs 0 on the next cycle;
  - a subsequent start runs cleanly with `err_cnt=0`.
